// File: rtl/hazard_unit.sv
// Load-use stall and taken-branch flush controller for a 5-stage pipeline.
// Control outputs are Mealy from state and inputs; counters and stalling are registered.
//   state | meaning
//   RUN   | normal flow, watching for load-use hazards and taken branches
//   STALL | extra load-use bubble cycles while cnt counts down to 1
module hazard_unit #(
  parameter int LOAD_STALL = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        idexMemRead,
  input  logic [4:0]  idexRt,
  input  logic [4:0]  ifidRs,
  input  logic [4:0]  ifidRt,
  input  logic        ifidUsesRt,
  input  logic        branchTaken,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        ifidFlush,
  output logic        idexFlush,
  output logic        exmemFlush,
  output logic        stalling,
  output logic [15:0] stallCycles,
  output logic [15:0] flushEvents
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [1:0] CNT_LOAD = 2'(LOAD_STALL - 1);

  state_t     state;
  logic [1:0] cnt;
  logic       loadUse;

  // x0 is hardwired to zero, so a load into it can never be a hazard
  assign loadUse = idexMemRead && (idexRt != 5'd0) &&
                   ((idexRt == ifidRs) || (ifidUsesRt && (idexRt == ifidRt)));

  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    exmemFlush = 1'b0;
    if (reset) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      ifidFlush  = 1'b1;
      idexFlush  = 1'b1;
      exmemFlush = 1'b1;
    end else if (branchTaken) begin
      ifidFlush  = 1'b1;
      idexFlush  = 1'b1;
      exmemFlush = 1'b1;
    end else if (state == STALL || loadUse) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      idexFlush = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= 2'd0;
      stalling    <= 1'b0;
      stallCycles <= 16'd0;
      flushEvents <= 16'd0;
    end else if (branchTaken) begin
      state    <= RUN;
      cnt      <= 2'd0;
      stalling <= 1'b0;
      if (flushEvents != 16'hFFFF) flushEvents <= flushEvents + 16'd1;
    end else if (state == STALL) begin
      if (stallCycles != 16'hFFFF) stallCycles <= stallCycles + 16'd1;
      cnt <= cnt - 2'd1;
      if (cnt == 2'd1) begin
        state    <= RUN;
        stalling <= 1'b0;
      end
    end else if (loadUse) begin
      if (stallCycles != 16'hFFFF) stallCycles <= stallCycles + 16'd1;
      // the first penalty cycle is spent in RUN; STALL covers the remainder
      if (LOAD_STALL > 1) begin
        state    <= STALL;
        cnt      <= CNT_LOAD;
        stalling <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: one instance with a 1-cycle and one with a 3-cycle
// load-use penalty, sharing the same input stimulus.
module tb_hazard_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        idexMemRead = 1'b0;
  logic [4:0]  idexRt = 5'd0;
  logic [4:0]  ifidRs = 5'd0;
  logic [4:0]  ifidRt = 5'd0;
  logic        ifidUsesRt = 1'b0;
  logic        branchTaken = 1'b0;

  logic        pc1, ifw1, iff1, idf1, exf1, st1;
  logic [15:0] sc1, fe1;
  logic        pc3, ifw3, iff3, idf3, exf3, st3;
  logic [15:0] sc3, fe3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hazard_unit #(.LOAD_STALL(1)) u1 (
    .clock(clock), .reset(reset), .idexMemRead(idexMemRead), .idexRt(idexRt),
    .ifidRs(ifidRs), .ifidRt(ifidRt), .ifidUsesRt(ifidUsesRt), .branchTaken(branchTaken),
    .pcWrite(pc1), .ifidWrite(ifw1), .ifidFlush(iff1), .idexFlush(idf1), .exmemFlush(exf1),
    .stalling(st1), .stallCycles(sc1), .flushEvents(fe1));

  hazard_unit #(.LOAD_STALL(3)) u3 (
    .clock(clock), .reset(reset), .idexMemRead(idexMemRead), .idexRt(idexRt),
    .ifidRs(ifidRs), .ifidRt(ifidRt), .ifidUsesRt(ifidUsesRt), .branchTaken(branchTaken),
    .pcWrite(pc3), .ifidWrite(ifw3), .ifidFlush(iff3), .idexFlush(idf3), .exmemFlush(exf3),
    .stalling(st3), .stallCycles(sc3), .flushEvents(fe3));

  // {pcWrite, ifidWrite, ifidFlush, idexFlush, exmemFlush}
  wire [4:0] ctl1 = {pc1, ifw1, iff1, idf1, exf1};
  wire [4:0] ctl3 = {pc3, ifw3, iff3, idf3, exf3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    idexMemRead = 1'b0; idexRt = 5'd0; ifidRs = 5'd0; ifidRt = 5'd0;
    ifidUsesRt = 1'b0; branchTaken = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int low_cnt;
    int stall_cnt;

    #3;
    chk("rst_ctl1", 32'(ctl1), 32'b00111);
    chk("rst_ctl3", 32'(ctl3), 32'b00111);
    chk("rst_cnt", {sc3, fe3}, 32'h0);
    chk("rst_stalling", 32'(st3), 32'h0);

    // load-use via rs, 1-cycle penalty
    do_reset();
    idexMemRead = 1'b1; idexRt = 5'd5; ifidRs = 5'd5;
    #1 chk("ls1_stall_ctl", 32'(ctl1), 32'b00010);
    tick();
    idexMemRead = 1'b0;
    #1 chk("ls1_resume_ctl", 32'(ctl1), 32'b11000);
    chk("ls1_stallcycles", 32'(sc1), 32'd1);
    chk("ls1_stalling", 32'(st1), 32'd0);

    // load-use via rt, 3-cycle penalty
    do_reset();
    idexMemRead = 1'b1; idexRt = 5'd7; ifidRt = 5'd7; ifidUsesRt = 1'b1; ifidRs = 5'd2;
    low_cnt = 0;
    stall_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (!pc3) low_cnt++;
      if (st3) stall_cnt++;
      tick();
      idexMemRead = 1'b0;
    end
    chk("ls3_pc_low_cycles", 32'(low_cnt), 32'd3);
    chk("ls3_stalling_cycles", 32'(stall_cnt), 32'd2);
    chk("ls3_stallcycles", 32'(sc3), 32'd3);

    // same registers but ID instruction does not read rt
    do_reset();
    idexMemRead = 1'b1; idexRt = 5'd7; ifidRt = 5'd7; ifidUsesRt = 1'b0; ifidRs = 5'd3;
    #1 chk("no_rt_use_ctl", 32'(ctl3), 32'b11000);
    tick();
    chk("no_rt_use_stalling", 32'(st3), 32'd0);
    chk("no_rt_use_sc", 32'(sc3), 32'd0);

    // x0 destination never stalls
    do_reset();
    idexMemRead = 1'b1; idexRt = 5'd0; ifidRs = 5'd0; ifidRt = 5'd0; ifidUsesRt = 1'b1;
    #1 chk("x0_ctl1", 32'(ctl1), 32'b11000);
    chk("x0_ctl3", 32'(ctl3), 32'b11000);
    tick();
    chk("x0_stalling", 32'(st3), 32'd0);
    chk("x0_sc", 32'(sc3), 32'd0);

    // taken branch in the second stall cycle
    do_reset();
    idexMemRead = 1'b1; idexRt = 5'd9; ifidRs = 5'd9;
    #1 chk("bms_first_ctl", 32'(ctl3), 32'b00010);
    tick();
    idexMemRead = 1'b0; branchTaken = 1'b1;
    #1 chk("bms_stalling_before", 32'(st3), 32'd1);
    chk("bms_branch_ctl", 32'(ctl3), 32'b11111);
    tick();
    branchTaken = 1'b0;
    #1 chk("bms_after_stalling", 32'(st3), 32'd0);
    chk("bms_after_ctl", 32'(ctl3), 32'b11000);
    chk("bms_flushevents", 32'(fe3), 32'd1);
    chk("bms_stallcycles", 32'(sc3), 32'd1);

    // simultaneous load-use and branch: branch wins
    do_reset();
    idexMemRead = 1'b1; idexRt = 5'd4; ifidRs = 5'd4; branchTaken = 1'b1;
    #1 chk("sim_ctl1", 32'(ctl1), 32'b11111);
    chk("sim_ctl3", 32'(ctl3), 32'b11111);
    tick();
    idle_inputs();
    #1 chk("sim_sc3", 32'(sc3), 32'd0);
    chk("sim_fe3", 32'(fe3), 32'd1);
    chk("sim_stalling", 32'(st3), 32'd0);

    // flushEvents saturation
    do_reset();
    branchTaken = 1'b1;
    repeat (65534) @(posedge clock);
    #1 chk("sat_fffe", 32'(fe1), 32'hFFFE);
    repeat (3) @(posedge clock);
    #1 chk("sat_ffff", 32'(fe1), 32'hFFFF);
    branchTaken = 1'b0;

    // asynchronous reset pulse between edges
    tick();
    idexMemRead = 1'b1; idexRt = 5'd6; ifidRs = 5'd6;
    tick();
    chk("pre_async_stalling", 32'(st3), 32'd1);
    #1 reset = 1'b1;
    #1 chk("async_cnt1", {sc1, fe1}, 32'h0);
    chk("async_cnt3", {sc3, fe3}, 32'h0);
    chk("async_ctl3", 32'(ctl3), 32'b00111);
    chk("async_stalling", 32'(st3), 32'd0);
    #1 reset = 1'b0;
    idle_inputs();
    tick();
    chk("post_async_ctl", 32'(ctl3), 32'b11000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
